// File: rtl/elgamal_encrypt_scheduler_if.sv
// ============================================================================
//  Module   : elgamal_encrypt_scheduler_if
//  Purpose  : Bundles the job stream, the modular-exponentiation engine
//             handshakes, the modular-multiplier handshakes and the ciphertext
//             output stream of the ElGamal encryption scheduler.
//             slave  = scheduler view, master = surrounding system view.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface elgamal_encrypt_scheduler_if #(
  parameter int SIZE = 64
);
  // Host job stream
  logic [SIZE-1:0] job_p;
  logic [SIZE-1:0] job_g;
  logic [SIZE-1:0] job_y;
  logic [SIZE-1:0] job_k;
  logic [SIZE-1:0] job_m;
  logic            job_tvalid;
  logic            job_tready;
  // Modular exponentiation engine
  logic [SIZE-1:0] exp_base;
  logic [SIZE-1:0] exp_power;
  logic [SIZE-1:0] exp_modulus;
  logic            exp_req_tvalid;
  logic            exp_req_tready;
  logic [SIZE-1:0] exp_res_tdata;
  logic            exp_res_tvalid;
  logic            exp_res_tready;
  // Modular multiplier
  logic [SIZE-1:0] mul_a;
  logic [SIZE-1:0] mul_b;
  logic [SIZE-1:0] mul_mod;
  logic            mul_req_tvalid;
  logic            mul_req_tready;
  logic [SIZE-1:0] mul_res_tdata;
  logic            mul_res_tvalid;
  logic            mul_res_tready;
  // Ciphertext output
  logic [SIZE-1:0] c1_tdata;
  logic [SIZE-1:0] c2_tdata;
  logic            out_tvalid;
  logic            out_tready;
  logic            err;

  modport slave (
    input  job_p, job_g, job_y, job_k, job_m, job_tvalid,
    output job_tready,
    output exp_base, exp_power, exp_modulus, exp_req_tvalid,
    input  exp_req_tready, exp_res_tdata, exp_res_tvalid,
    output exp_res_tready,
    output mul_a, mul_b, mul_mod, mul_req_tvalid,
    input  mul_req_tready, mul_res_tdata, mul_res_tvalid,
    output mul_res_tready,
    output c1_tdata, c2_tdata, out_tvalid, err,
    input  out_tready
  );

  modport master (
    output job_p, job_g, job_y, job_k, job_m, job_tvalid,
    input  job_tready,
    input  exp_base, exp_power, exp_modulus, exp_req_tvalid,
    output exp_req_tready, exp_res_tdata, exp_res_tvalid,
    input  exp_res_tready,
    input  mul_a, mul_b, mul_mod, mul_req_tvalid,
    output mul_req_tready, mul_res_tdata, mul_res_tvalid,
    input  mul_res_tready,
    input  c1_tdata, c2_tdata, out_tvalid, err,
    output out_tready
  );
endinterface

`default_nettype wire

// File: rtl/elgamal_encrypt_scheduler.sv
// ============================================================================
//  Module   : elgamal_encrypt_scheduler
//  Purpose  : Sequences one ElGamal encryption (c1 = g^k mod p,
//             s = y^k mod p, c2 = m*s mod p) over one shared modexp engine
//             and one modular multiplier. One job in flight at a time.
//  Options  : ELGAMAL_SCHED_PERF_EN adds the 32-bit 'cycles' latency port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module elgamal_encrypt_scheduler #(
  parameter int SIZE = 64
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
`ifdef ELGAMAL_SCHED_PERF_EN
  output logic [31:0]                 cycles,
`endif
  elgamal_encrypt_scheduler_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_EXP1_REQ  = 4'd1,
    S_EXP1_WAIT = 4'd2,
    S_EXP2_REQ  = 4'd3,
    S_EXP2_WAIT = 4'd4,
    S_MUL_REQ   = 4'd5,
    S_MUL_WAIT  = 4'd6,
    S_OUT       = 4'd7
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [SIZE-1:0] r_p, r_g, r_y, r_k, r_m;
  logic [SIZE-1:0] r_s;
  logic [SIZE-1:0] r_c1, r_c2;
  logic            r_err;

  logic            w_accept;
  logic            w_bad_p;
  logic            w_exp2;

  assign w_accept = (r_state == S_IDLE) && bus.job_tvalid;
  assign w_bad_p  = (bus.job_p < SIZE'(2));
  assign w_exp2   = (r_state == S_EXP2_REQ) || (r_state == S_EXP2_WAIT);

  // Operands come straight from the job latches, so they stay stable while
  // a request waits for ready.
  assign bus.exp_base    = w_exp2 ? r_y : r_g;
  assign bus.exp_power   = r_k;
  assign bus.exp_modulus = r_p;
  assign bus.mul_a       = r_m;
  assign bus.mul_b       = r_s;
  assign bus.mul_mod     = r_p;
  assign bus.c1_tdata    = r_c1;
  assign bus.c2_tdata    = r_c2;
  assign bus.err         = r_err;

  // State register; async reset returns to IDLE and drops every valid at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and handshake strobes, all derived from the current state.
  always_comb begin
    w_next             = r_state;
    bus.job_tready     = 1'b0;
    bus.exp_req_tvalid = 1'b0;
    bus.exp_res_tready = 1'b0;
    bus.mul_req_tvalid = 1'b0;
    bus.mul_res_tready = 1'b0;
    bus.out_tvalid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.job_tready = 1'b1;
        if (bus.job_tvalid) w_next = w_bad_p ? S_OUT : S_EXP1_REQ;
      end
      S_EXP1_REQ: begin
        bus.exp_req_tvalid = 1'b1;
        if (bus.exp_req_tready) w_next = S_EXP1_WAIT;
      end
      S_EXP1_WAIT: begin
        bus.exp_res_tready = 1'b1;
        if (bus.exp_res_tvalid) w_next = S_EXP2_REQ;
      end
      S_EXP2_REQ: begin
        bus.exp_req_tvalid = 1'b1;
        if (bus.exp_req_tready) w_next = S_EXP2_WAIT;
      end
      S_EXP2_WAIT: begin
        bus.exp_res_tready = 1'b1;
        if (bus.exp_res_tvalid) w_next = S_MUL_REQ;
      end
      S_MUL_REQ: begin
        bus.mul_req_tvalid = 1'b1;
        if (bus.mul_req_tready) w_next = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        bus.mul_res_tready = 1'b1;
        if (bus.mul_res_tvalid) w_next = S_OUT;
      end
      S_OUT: begin
        bus.out_tvalid = 1'b1;
        if (bus.out_tready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Job latches and result capture; results are taken only inside their WAIT state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p   <= '0;
      r_g   <= '0;
      r_y   <= '0;
      r_k   <= '0;
      r_m   <= '0;
      r_s   <= '0;
      r_c1  <= '0;
      r_c2  <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.job_tvalid) begin
            r_p   <= bus.job_p;
            r_g   <= bus.job_g;
            r_y   <= bus.job_y;
            r_k   <= bus.job_k;
            r_m   <= bus.job_m;
            r_c1  <= '0;
            r_c2  <= '0;
            r_err <= w_bad_p;
          end
        end
        S_EXP1_WAIT: if (bus.exp_res_tvalid) r_c1 <= bus.exp_res_tdata;
        S_EXP2_WAIT: if (bus.exp_res_tvalid) r_s  <= bus.exp_res_tdata;
        S_MUL_WAIT:  if (bus.mul_res_tvalid) r_c2 <= bus.mul_res_tdata;
        S_OUT:       if (bus.out_tready)     r_err <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef ELGAMAL_SCHED_PERF_EN
  logic [31:0] r_cycles;
  logic        w_busy;

  assign w_busy = (r_state != S_IDLE) && (r_state != S_OUT);
  assign cycles = r_cycles;

  // Latency counter: the cycle entered on accept counts as 1, then one per
  // busy cycle, so it reads the number of cycles up to and including OUT entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_cycles <= '0;
    else if (w_accept)                   r_cycles <= 32'd1;
    else if (w_busy && (r_cycles != '1)) r_cycles <= r_cycles + 32'd1;
  end
`else
  logic w_unused_accept;
  assign w_unused_accept = w_accept;
`endif

endmodule

`default_nettype wire

// File: tb/tb_elgamal_encrypt_scheduler.sv
`default_nettype none

module tb_elgamal_encrypt_scheduler;
  localparam int SIZE = 64;

  typedef struct {
    logic [63:0] c1;
    logic [63:0] c2;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  elgamal_encrypt_scheduler_if #(.SIZE(SIZE)) bus ();

`ifdef ELGAMAL_SCHED_PERF_EN
  logic [31:0] cycles;
`endif

  elgamal_encrypt_scheduler #(.SIZE(SIZE)) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef ELGAMAL_SCHED_PERF_EN
    .cycles (cycles),
`endif
    .bus    (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  function automatic logic [63:0] f_modexp(input logic [63:0] b, input logic [63:0] e,
                                           input logic [63:0] m);
    logic [127:0] r;
    logic [127:0] x;
    logic [127:0] mm;
    mm = {64'd0, m};
    x  = {64'd0, b} % mm;
    r  = 128'd1 % mm;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[63:0];
  endfunction

  function automatic logic [63:0] f_mulmod(input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] m);
    logic [127:0] r;
    r = ({64'd0, a} * {64'd0, b}) % {64'd0, m};
    return r[63:0];
  endfunction

  // ---------------- engine models ----------------
  int          exp_lat = 4;
  int          mul_lat = 4;
  logic        exp_stall = 1'b0;
  logic        spur_exp  = 1'b0;
  logic        r_exp_v, r_exp_pend, r_mul_v, r_mul_pend;
  logic [63:0] r_exp_d, r_mul_d;
  int          r_exp_cnt, r_mul_cnt;
  int          exp_req_seen = 0;

  assign bus.exp_req_tready = ~exp_stall;
  assign bus.exp_res_tvalid = r_exp_v | spur_exp;
  assign bus.exp_res_tdata  = spur_exp ? 64'd99 : r_exp_d;
  assign bus.mul_req_tready = 1'b1;
  assign bus.mul_res_tvalid = r_mul_v;
  assign bus.mul_res_tdata  = r_mul_d;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exp_v <= 1'b0; r_exp_pend <= 1'b0; r_exp_cnt <= 0; r_exp_d <= '0;
    end else begin
      if (r_exp_v && bus.exp_res_tready) r_exp_v <= 1'b0;
      if (bus.exp_req_tvalid && bus.exp_req_tready) begin
        r_exp_d <= f_modexp(bus.exp_base, bus.exp_power, bus.exp_modulus);
        if (exp_lat == 0) r_exp_v <= 1'b1;
        else begin r_exp_pend <= 1'b1; r_exp_cnt <= exp_lat - 1; end
      end else if (r_exp_pend) begin
        if (r_exp_cnt == 0) begin r_exp_v <= 1'b1; r_exp_pend <= 1'b0; end
        else r_exp_cnt <= r_exp_cnt - 1;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mul_v <= 1'b0; r_mul_pend <= 1'b0; r_mul_cnt <= 0; r_mul_d <= '0;
    end else begin
      if (r_mul_v && bus.mul_res_tready) r_mul_v <= 1'b0;
      if (bus.mul_req_tvalid && bus.mul_req_tready) begin
        r_mul_d <= f_mulmod(bus.mul_a, bus.mul_b, bus.mul_mod);
        if (mul_lat == 0) r_mul_v <= 1'b1;
        else begin r_mul_pend <= 1'b1; r_mul_cnt <= mul_lat - 1; end
      end else if (r_mul_pend) begin
        if (r_mul_cnt == 0) begin r_mul_v <= 1'b1; r_mul_pend <= 1'b0; end
        else r_mul_cnt <= r_mul_cnt - 1;
      end
    end
  end

  always @(posedge clk) if (bus.exp_req_tvalid) exp_req_seen <= exp_req_seen + 1;

  // ---------------- stimulus helpers ----------------
  task automatic send_job(input logic [63:0] p, input logic [63:0] g, input logic [63:0] y,
                          input logic [63:0] k, input logic [63:0] m);
    exp_t e;
    int   n;
    if (p < 64'd2) begin
      e.c1 = '0; e.c2 = '0; e.err = 1'b1;
    end else begin
      e.c1  = f_modexp(g, k, p);
      e.c2  = f_mulmod(m, f_modexp(y, k, p), p);
      e.err = 1'b0;
    end
    sb.push_back(e);
    @(negedge clk);
    bus.job_p = p; bus.job_g = g; bus.job_y = y; bus.job_k = k; bus.job_m = m;
    bus.job_tvalid = 1'b1;
    n = 0;
    while (!bus.job_tready && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.job_tvalid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_tvalid && n < 300) begin @(negedge clk); n++; end
  endtask

  task automatic pulse_out;
    bus.out_tready = 1'b1;
    @(negedge clk);
    bus.out_tready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.exp_req_tvalid, bus.exp_res_tready, bus.mul_req_tvalid, bus.mul_res_tready,
         bus.out_tvalid, bus.err, bus.job_tready} !== 7'b0000001) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000001", {bus.exp_req_tvalid,
               bus.exp_res_tready, bus.mul_req_tvalid, bus.mul_res_tready, bus.out_tvalid,
               bus.err, bus.job_tready});
    end
    n_checks++;
    if ({bus.c1_tdata, bus.c2_tdata, bus.exp_base, bus.mul_b} !== 256'd0) begin
      n_fail++;
      $display("FAIL reset_data: got c1=%0d c2=%0d base=%0d mul_b=%0d expected 0",
               bus.c1_tdata, bus.c2_tdata, bus.exp_base, bus.mul_b);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int   n;
    exp_t e;
    exp_lat = 4; mul_lat = 4;
    send_job(64'd23, 64'd5, 64'd8, 64'd3, 64'd10);
    wait_out(n);
    n_checks++;
    if (bus.out_tvalid !== 1'b1) begin
      n_fail++; $display("FAIL basic_timeout: out_tvalid=%b expected 1", bus.out_tvalid);
    end
    e = sb.pop_front();
    n_checks++;
    if ({bus.c1_tdata, bus.c2_tdata, bus.err} !== {e.c1, e.c2, e.err}) begin
      n_fail++;
      $display("FAIL basic_result: got c1=%0d c2=%0d err=%b expected c1=%0d c2=%0d err=%b",
               bus.c1_tdata, bus.c2_tdata, bus.err, e.c1, e.c2, e.err);
    end
    pulse_out();
    n_checks++;
    if ({bus.out_tvalid, bus.err, bus.job_tready} !== 3'b001) begin
      n_fail++;
      $display("FAIL basic_release: got out_tvalid/err/job_tready=%b expected 001",
               {bus.out_tvalid, bus.err, bus.job_tready});
    end
  endtask

  task automatic test_patterns;
    logic [63:0] tbl [4][5];
    int   n;
    exp_t e;
    tbl[0] = '{64'd1000003, 64'd2000000, 64'd7, 64'd0, 64'd999};
    tbl[1] = '{64'd97, 64'd3, 64'd5, 64'd10, 64'd150};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFC5, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFD0,
               64'h0FED_CBA9_8765_4321, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[3] = '{64'd2, 64'd3, 64'd5, 64'd7, 64'd1};
    exp_lat = 0; mul_lat = 0;
    for (int i = 0; i < 4; i++) begin
      send_job(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4]);
      wait_out(n);
      n_checks++;
      if (n !== 6) begin
        n_fail++; $display("FAIL pattern%0d_latency: got %0d expected 6 negedges", i, n);
      end
      e = sb.pop_front();
      n_checks++;
      if ({bus.c1_tdata, bus.c2_tdata, bus.err} !== {e.c1, e.c2, e.err}) begin
        n_fail++;
        $display("FAIL pattern%0d_result: got c1=%0d c2=%0d err=%b expected c1=%0d c2=%0d err=%b",
                 i, bus.c1_tdata, bus.c2_tdata, bus.err, e.c1, e.c2, e.err);
      end
      pulse_out();
    end
  endtask

  task automatic test_err;
    int   n, seen0;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      seen0 = exp_req_seen;
      send_job((i == 0) ? 64'd1 : 64'd0, 64'd5, 64'd8, 64'd3, 64'd10);
      wait_out(n);
      n_checks++;
      if (n > 1) begin
        n_fail++; $display("FAIL err%0d_latency: got %0d expected <=1 negedges", i, n);
      end
      e = sb.pop_front();
      n_checks++;
      if ({bus.c1_tdata, bus.c2_tdata, bus.err} !== {e.c1, e.c2, e.err}) begin
        n_fail++;
        $display("FAIL err%0d_result: got c1=%0d c2=%0d err=%b expected c1=%0d c2=%0d err=%b",
                 i, bus.c1_tdata, bus.c2_tdata, bus.err, e.c1, e.c2, e.err);
      end
      pulse_out();
      n_checks++;
      if (exp_req_seen !== seen0) begin
        n_fail++;
        $display("FAIL err%0d_no_exp_req: got %0d request cycles expected 0", i,
                 exp_req_seen - seen0);
      end
    end
  endtask

  task automatic test_req_stall;
    int   n;
    exp_t e;
    exp_lat = 4; mul_lat = 4;
    exp_stall = 1'b1;
    send_job(64'd23, 64'd5, 64'd8, 64'd3, 64'd10);
    n = 0;
    while (!bus.exp_req_tvalid && n < 50) begin @(negedge clk); n++; end
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if ({bus.exp_req_tvalid, bus.exp_base, bus.exp_power, bus.exp_modulus} !==
          {1'b1, 64'd5, 64'd3, 64'd23}) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: got v=%b base=%0d pow=%0d mod=%0d expected v=1 5 3 23",
                 c, bus.exp_req_tvalid, bus.exp_base, bus.exp_power, bus.exp_modulus);
      end
      @(negedge clk);
    end
    exp_stall = 1'b0;
    wait_out(n);
    e = sb.pop_front();
    n_checks++;
    if ({bus.out_tvalid, bus.c1_tdata, bus.c2_tdata, bus.err} !== {1'b1, e.c1, e.c2, e.err}) begin
      n_fail++;
      $display("FAIL stall_result: got v=%b c1=%0d c2=%0d err=%b expected v=1 c1=%0d c2=%0d err=%b",
               bus.out_tvalid, bus.c1_tdata, bus.c2_tdata, bus.err, e.c1, e.c2, e.err);
    end
    pulse_out();
  endtask

  task automatic test_out_hold;
    int   n;
    exp_t e;
    send_job(64'd23, 64'd5, 64'd8, 64'd3, 64'd10);
    wait_out(n);
    e = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({bus.out_tvalid, bus.job_tready, bus.c1_tdata, bus.c2_tdata, bus.err} !==
          {1'b1, 1'b0, e.c1, e.c2, e.err}) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got v=%b jr=%b c1=%0d c2=%0d expected v=1 jr=0 c1=%0d c2=%0d",
                 c, bus.out_tvalid, bus.job_tready, bus.c1_tdata, bus.c2_tdata, e.c1, e.c2);
      end
      @(negedge clk);
    end
    pulse_out();
  endtask

  task automatic test_spurious;
    int   n;
    exp_t e;
    send_job(64'd23, 64'd5, 64'd8, 64'd3, 64'd10);
    n = 0;
    while (!bus.mul_res_tready && n < 100) begin @(negedge clk); n++; end
    spur_exp = 1'b1;
    @(negedge clk);
    spur_exp = 1'b0;
    wait_out(n);
    e = sb.pop_front();
    n_checks++;
    if ({bus.out_tvalid, bus.c1_tdata, bus.c2_tdata} !== {1'b1, e.c1, e.c2}) begin
      n_fail++;
      $display("FAIL spurious_result: got v=%b c1=%0d c2=%0d expected v=1 c1=%0d c2=%0d",
               bus.out_tvalid, bus.c1_tdata, bus.c2_tdata, e.c1, e.c2);
    end
    pulse_out();
  endtask

  task automatic test_reset_mid;
    int   n;
    exp_t e;
    send_job(64'd23, 64'd5, 64'd8, 64'd3, 64'd10);
    n = 0;
    while (!(bus.exp_res_tready && bus.exp_base == 64'd8) && n < 100) begin
      @(negedge clk); n++;
    end
    n_checks++;
    if (n >= 100) begin
      n_fail++; $display("FAIL midreset_reach: got timeout expected EXP2_WAIT");
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.exp_req_tvalid, bus.exp_res_tready, bus.mul_req_tvalid, bus.out_tvalid,
         bus.job_tready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL midreset_valids: got %b expected 00001", {bus.exp_req_tvalid,
               bus.exp_res_tready, bus.mul_req_tvalid, bus.out_tvalid, bus.job_tready});
    end
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_front());
    send_job(64'd23, 64'd5, 64'd8, 64'd3, 64'd10);
    wait_out(n);
    e = sb.pop_front();
    n_checks++;
    if ({bus.out_tvalid, bus.c1_tdata, bus.c2_tdata, bus.err} !== {1'b1, e.c1, e.c2, e.err}) begin
      n_fail++;
      $display("FAIL midreset_result: got v=%b c1=%0d c2=%0d expected v=1 c1=%0d c2=%0d",
               bus.out_tvalid, bus.c1_tdata, bus.c2_tdata, e.c1, e.c2);
    end
    pulse_out();
  endtask

`ifdef ELGAMAL_SCHED_PERF_EN
  task automatic test_perf;
    int n;
    exp_lat = 0; mul_lat = 0;
    send_job(64'd23, 64'd5, 64'd8, 64'd3, 64'd10);
    void'(sb.pop_front());
    wait_out(n);
    n_checks++;
    if (cycles !== 32'd7) begin
      n_fail++; $display("FAIL perf_cycles: got %0d expected 7", cycles);
    end
    pulse_out();
    repeat (3) @(negedge clk);
    n_checks++;
    if (cycles !== 32'd7) begin
      n_fail++; $display("FAIL perf_hold: got %0d expected 7", cycles);
    end
  endtask
`endif

  initial begin
    bus.job_tvalid = 1'b0;
    bus.out_tready = 1'b0;
    bus.job_p = '0; bus.job_g = '0; bus.job_y = '0; bus.job_k = '0; bus.job_m = '0;
    test_reset();
    test_basic();
    test_patterns();
    test_err();
    test_req_stall();
    test_out_hold();
    test_spurious();
    test_reset_mid();
`ifdef ELGAMAL_SCHED_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
